seg_scan_driver: RTL and testbench

- Time-multiplexed scan driver for a common-anode multi-digit 7-segment display.
- Holds an N_DIGITS-nibble display value and walks one digit at a time at a programmable refresh rate.
- Feeds the current nibble to the ISegmentDisplay decoder, then drives the registered segment byte and active-low anode enables to the pins.
- New values are double-buffered and committed only at frame boundaries, so no digit ever tears.

---
 rtl/seg_scan_driver_pkg.sv | 10 +
 rtl/seg_scan_driver_decoder.sv | 32 +++
 rtl/seg_scan_driver.sv | 123 ++++++++++++
 tb/tb_seg_scan_driver.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment bytes are active-low, segments a..g in bits 7..1 and the decimal point in bit 0.
package seg_scan_driver_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SEG_BLANK  = 8'hFF;
    localparam int    SEG_DP_BIT = 0;

endpackage

// File: rtl/seg_scan_driver_decoder.sv
// Hex nibble to active-low 7-segment pattern; the dp bit is always returned unlit.
module seg_scan_driver_decoder
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] nib,
    output byte_t      c
);

    always_comb begin
        c = SEG_BLANK;
        case (nib)
            4'h0: c = 8'h03;
            4'h1: c = 8'h9F;
            4'h2: c = 8'h25;
            4'h3: c = 8'h0D;
            4'h4: c = 8'h99;
            4'h5: c = 8'h49;
            4'h6: c = 8'h41;
            4'h7: c = 8'h1F;
            4'h8: c = 8'h01;
            4'h9: c = 8'h09;
            4'hA: c = 8'h11;
            4'hB: c = 8'hC1;
            4'hC: c = 8'h63;
            4'hD: c = 8'h85;
            4'hE: c = 8'h61;
            4'hF: c = 8'h71;
            default: c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode scan driver with frame-synchronous double buffering.
// Outputs are registered, so pins lag the internal cnt/idx/disp state by one cycle.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DIV      = 100000,
    parameter int DEAD     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  blank_lz,
    output logic [N_DIGITS-1:0]   an,
    output byte_t                 seg,
    output logic                  upd_pending,
    output logic                  frame_tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  frame_wrap;

    logic [4*N_DIGITS-1:0] disp_val;
    logic [N_DIGITS-1:0]   disp_dp;
    logic [4*N_DIGITS-1:0] pend_val;
    logic [N_DIGITS-1:0]   pend_dp;

    logic [3:0]            nib;
    byte_t                 dec;
    logic [N_DIGITS-1:0]   lz_zero;
    logic                  blank_digit;
    logic [N_DIGITS-1:0]   an_c;
    byte_t                 seg_c;

    assign tick       = (cnt == CNT_LAST);
    assign frame_wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + 1'b1;
            frame_tick <= frame_wrap;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
        end
    end

    // Commit reads the old pending contents, so a load landing on the wrap
    // cycle is held over for the following frame instead of being lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_val    <= '0;
            disp_dp     <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            upd_pending <= 1'b0;
        end else begin
            if (frame_wrap && upd_pending) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (load) begin
                pend_val    <= value;
                pend_dp     <= dp_mask;
                upd_pending <= 1'b1;
            end else if (frame_wrap) begin
                upd_pending <= 1'b0;
            end
        end
    end

    assign nib = disp_val[4*idx +: 4];

    seg_scan_driver_decoder u_decoder (
        .nib (nib),
        .c   (dec)
    );

    // lz_zero[i] is set when digit i and every more significant digit are zero.
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign lz_zero[gi] = ~|disp_val[4*N_DIGITS-1 : 4*gi];
            assign an_c[gi]    = ~((cnt >= CNT_DEAD) && (idx == IDX_W'(gi)));
        end
    endgenerate

    assign blank_digit = blank_lz && (idx != '0) && lz_zero[idx];

    always_comb begin
        seg_c = dec;
        if (blank_digit) begin
            seg_c[7:1] = 7'h7F;
        end
        seg_c[SEG_DP_BIT] = ~disp_dp[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_c;
            seg <= seg_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with N_DIGITS=4, DIV=4, DEAD=1 (16-cycle frames).
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        upd_pending;
    logic        frame_tick;

    int compared   = 0;
    int mismatched = 0;

    seg_scan_driver #(
        .N_DIGITS (4),
        .DIV      (4),
        .DEAD     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .blank_lz    (blank_lz),
        .an          (an),
        .seg         (seg),
        .upd_pending (upd_pending),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at the negedge where frame_tick is observed high.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Samples the 16 negedges of one frame; segs holds the lit seg byte per digit.
    task automatic capture_frame(output logic [31:0] segs, output logic [63:0] ans,
                                 output logic [15:0] fts);
        segs = '1;
        ans  = '0;
        fts  = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ans[4*k +: 4] = an;
            fts[k]        = frame_tick;
            for (int d = 0; d < 4; d++) begin
                if (an[d] === 1'b0) segs[8*d +: 8] = seg;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] segs, exp_segs;
        logic [63:0] ans;
        logic [15:0] fts;
        logic [3:0]  exp_an;
        bit          ok;
        rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (an !== 4'hF) begin mismatched++; $display("FAIL reset_an got=%h exp=F", an); end
        compared++;
        if (seg !== 8'hFF) begin mismatched++; $display("FAIL reset_seg got=%h exp=FF", seg); end
        compared++;
        if (upd_pending !== 1'b0) begin mismatched++; $display("FAIL reset_upd got=%b exp=0", upd_pending); end
        compared++;
        if (frame_tick !== 1'b0) begin mismatched++; $display("FAIL reset_ft got=%b exp=0", frame_tick); end
        rst = 1'b0;
        wait_frame(ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL reset_wait_frame got=timeout exp=frame_tick"); end
        capture_frame(segs, ans, fts);
        exp_segs = {8'hFF, 8'hFF, 8'hFF, 8'h03};
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (segs[8*d +: 8] !== exp_segs[8*d +: 8]) begin
                mismatched++;
                $display("FAIL reset_digit%0d_seg got=%h exp=%h", d, segs[8*d +: 8], exp_segs[8*d +: 8]);
            end
        end
        for (int k = 0; k < 16; k++) begin
            exp_an = (k % 4 == 0) ? 4'hF : ~(4'b0001 << (k / 4));
            compared++;
            if (ans[4*k +: 4] !== exp_an) begin
                mismatched++;
                $display("FAIL reset_an_seq[%0d] got=%h exp=%h", k, ans[4*k +: 4], exp_an);
            end
            compared++;
            if (fts[k] !== (k == 15)) begin
                mismatched++;
                $display("FAIL reset_ft_seq[%0d] got=%b exp=%b", k, fts[k], (k == 15));
            end
        end
        $display("test_reset: done, %0d compared so far", compared);
    endtask

    task automatic test_load;
        logic [31:0] segs, exp_segs;
        logic [63:0] ans;
        logic [15:0] fts;
        bit          ok;
        blank_lz = 1'b0;
        load = 1'b1; value = 16'h12AF; dp_mask = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        compared++;
        if (upd_pending !== 1'b1) begin mismatched++; $display("FAIL load_upd_set got=%b exp=1", upd_pending); end
        wait_frame(ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL load_wait_frame got=timeout exp=frame_tick"); end
        compared++;
        if (upd_pending !== 1'b0) begin mismatched++; $display("FAIL load_upd_clear got=%b exp=0", upd_pending); end
        capture_frame(segs, ans, fts);
        // digit3='1', digit2='2' with dp, digit1='A', digit0='F'
        exp_segs = {8'h9F, 8'h24, 8'h11, 8'h71};
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (segs[8*d +: 8] !== exp_segs[8*d +: 8]) begin
                mismatched++;
                $display("FAIL load_digit%0d_seg got=%h exp=%h", d, segs[8*d +: 8], exp_segs[8*d +: 8]);
            end
        end
        $display("test_load: value=12AF dp=0100 shown, %0d compared so far", compared);
    endtask

    task automatic test_blank;
        logic [31:0] segs, exp_segs;
        logic [63:0] ans;
        logic [15:0] fts;
        bit          ok;
        blank_lz = 1'b1;
        load = 1'b1; value = 16'h0070; dp_mask = 4'b0000;
        @(negedge clk);
        load = 1'b0;
        wait_frame(ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL blank_wait_frame got=timeout exp=frame_tick"); end
        capture_frame(segs, ans, fts);
        exp_segs = {8'hFF, 8'hFF, 8'h1F, 8'h03};
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (segs[8*d +: 8] !== exp_segs[8*d +: 8]) begin
                mismatched++;
                $display("FAIL blank_digit%0d_seg got=%h exp=%h", d, segs[8*d +: 8], exp_segs[8*d +: 8]);
            end
        end
        $display("test_blank: value=0070 blanked, %0d compared so far", compared);
    endtask

    // Starts at a frame_tick negedge; B is presented exactly on the next wrap edge.
    task automatic test_back_to_back;
        logic [31:0] segs, exp_a, exp_b;
        logic [63:0] ans;
        logic [15:0] fts;
        blank_lz = 1'b0;
        load = 1'b1; value = 16'h3456; dp_mask = 4'b0001;
        @(negedge clk);
        load = 1'b0;
        repeat (14) @(negedge clk);
        load = 1'b1; value = 16'hBCDE; dp_mask = 4'b1000;
        @(negedge clk);
        load = 1'b0;
        compared++;
        if (frame_tick !== 1'b1) begin mismatched++; $display("FAIL b2b_wrap_align got=%b exp=1", frame_tick); end
        compared++;
        if (upd_pending !== 1'b1) begin mismatched++; $display("FAIL b2b_upd_held got=%b exp=1", upd_pending); end
        capture_frame(segs, ans, fts);
        exp_a = {8'h0D, 8'h99, 8'h49, 8'h40};
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (segs[8*d +: 8] !== exp_a[8*d +: 8]) begin
                mismatched++;
                $display("FAIL b2b_A_digit%0d_seg got=%h exp=%h", d, segs[8*d +: 8], exp_a[8*d +: 8]);
            end
        end
        capture_frame(segs, ans, fts);
        exp_b = {8'hC0, 8'h63, 8'h85, 8'h61};
        for (int d = 0; d < 4; d++) begin
            compared++;
            if (segs[8*d +: 8] !== exp_b[8*d +: 8]) begin
                mismatched++;
                $display("FAIL b2b_B_digit%0d_seg got=%h exp=%h", d, segs[8*d +: 8], exp_b[8*d +: 8]);
            end
        end
        compared++;
        if (upd_pending !== 1'b0) begin mismatched++; $display("FAIL b2b_upd_final got=%b exp=0", upd_pending); end
        $display("test_back_to_back: A=3456 then B=BCDE, %0d compared so far", compared);
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_an;
        bit         found;
        load = 1'b1; value = 16'h9999; dp_mask = 4'b1111;
        @(negedge clk);
        load = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (an === 4'hB) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (found !== 1'b1) begin mismatched++; $display("FAIL rstmid_find_anB got=timeout exp=an_B"); end
        compared++;
        if (upd_pending !== 1'b1) begin mismatched++; $display("FAIL rstmid_upd_before got=%b exp=1", upd_pending); end
        #1 rst = 1'b1;
        #1;
        compared++;
        if (an !== 4'hF) begin mismatched++; $display("FAIL rstmid_an got=%h exp=F", an); end
        compared++;
        if (seg !== 8'hFF) begin mismatched++; $display("FAIL rstmid_seg got=%h exp=FF", seg); end
        compared++;
        if (upd_pending !== 1'b0) begin mismatched++; $display("FAIL rstmid_upd got=%b exp=0", upd_pending); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_an = (k % 4 == 0) ? 4'hF : 4'hE;
            compared++;
            if (an !== exp_an) begin
                mismatched++;
                $display("FAIL rstmid_restart_an[%0d] got=%h exp=%h", k, an, exp_an);
            end
            if (k == 1) begin
                compared++;
                if (seg !== 8'h03) begin mismatched++; $display("FAIL rstmid_restart_seg got=%h exp=03", seg); end
            end
        end
        $display("test_reset_mid: restart at digit 0, %0d compared so far", compared);
    endtask

    task automatic test_frame_tick;
        int  zeros;
        bit  ok;
        wait_frame(ok);
        compared++;
        if (ok !== 1'b1) begin mismatched++; $display("FAIL ft_wait_frame got=timeout exp=frame_tick"); end
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            compared++;
            if (frame_tick !== (k % 16 == 15)) begin
                mismatched++;
                $display("FAIL ft_pulse[%0d] got=%b exp=%b", k, frame_tick, (k % 16 == 15));
            end
            zeros = 0;
            for (int d = 0; d < 4; d++) if (an[d] === 1'b0) zeros++;
            compared++;
            if (zeros > 1) begin
                mismatched++;
                $display("FAIL ft_an_onehot[%0d] got=%h exp=at_most_one_low", k, an);
            end
        end
        $display("test_frame_tick: 64 cycles checked, %0d compared so far", compared);
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_frame_tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
